// File: rtl/riscv_mini_fetch.sv
// Instruction fetch front-end for a small 16-bit core: assembles a byte stream
// into a program memory, then issues instructions with branch redirection.
module riscv_mini_fetch #(
   parameter int          DEPTH = 16,
   parameter logic [15:0] NOP   = 16'h0003
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   input  logic        clear,
   input  logic        start,
   input  logic        halt,
   input  logic        taken,
   input  logic [3:0]  target,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic [3:0]  pc,
   output logic [4:0]  prog_len,
   output logic [1:0]  state,
   output logic        overflow
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] DEPTH_L = 5'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_LOAD_HI = 2'b01,
      S_RUN     = 2'b10,
      S_DONE    = 2'b11
   } state_t;

   state_t      state_reg, state_next;
   logic [3:0]  pc_reg, pc_next;
   logic [4:0]  prog_len_reg, prog_len_next;
   logic        overflow_reg, overflow_next;
   logic [7:0]  holding_reg, holding_next;
   logic [15:0] mem [DEPTH];

   logic        mem_full;
   logic        can_start;
   logic        wr_en;
   logic [4:0]  pc_target;

   assign mem_full  = (prog_len_reg == DEPTH_L);
   assign can_start = start && (prog_len_reg != 5'd0);
   assign wr_en     = (state_reg == S_LOAD_HI) && byte_valid && !clear;
   // Kept at 5 bits so running off the end of a full 16-entry program is seen.
   assign pc_target = taken ? {1'b0, target} : ({1'b0, pc_reg} + 5'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         pc_reg       <= 4'd0;
         prog_len_reg <= 5'd0;
         overflow_reg <= 1'b0;
         holding_reg  <= 8'd0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         prog_len_reg <= prog_len_next;
         overflow_reg <= overflow_next;
         holding_reg  <= holding_next;
      end
   end

   // Memory is not reset; rst_n gates the write so a reset edge aborts a load.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         mem[prog_len_reg[AW-1:0]] <= {byte_in, holding_reg};
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      prog_len_next = prog_len_reg;
      overflow_next = overflow_reg;
      holding_next  = holding_reg;
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (clear) begin
               prog_len_next = 5'd0;
               overflow_next = 1'b0;
               state_next    = S_IDLE;
            end else if (can_start) begin
               pc_next    = 4'd0;
               state_next = S_RUN;
            end else if ((state_reg == S_IDLE) && byte_valid) begin
               if (mem_full) begin
                  overflow_next = 1'b1;
               end else begin
                  holding_next = byte_in;
                  state_next   = S_LOAD_HI;
               end
            end
         end
         S_LOAD_HI: begin
            if (clear) begin
               prog_len_next = 5'd0;
               overflow_next = 1'b0;
               holding_next  = 8'd0;
               state_next    = S_IDLE;
            end else if (byte_valid) begin
               prog_len_next = prog_len_reg + 5'd1;
               state_next    = S_IDLE;
            end
         end
         S_RUN: begin
            if (halt) begin
               pc_next    = 4'd0;
               state_next = S_IDLE;
            end else if (pc_target >= prog_len_reg) begin
               state_next = S_DONE;
            end else begin
               pc_next = pc_target[3:0];
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      instr       = NOP;
      instr_valid = 1'b0;
      if (state_reg == S_RUN) begin
         instr       = mem[pc_reg[AW-1:0]];
         instr_valid = 1'b1;
      end
   end

   assign pc       = pc_reg;
   assign prog_len = prog_len_reg;
   assign state    = state_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_riscv_mini_fetch.sv
// Directed bench for riscv_mini_fetch: loading, issue, branches, halt,
// overflow, clear and asynchronous reset, each against hand-computed values.
module tb_riscv_mini_fetch;

   logic        clk;
   logic        rst_n;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        clear;
   logic        start;
   logic        halt;
   logic        taken;
   logic [3:0]  target;
   logic [15:0] instr;
   logic        instr_valid;
   logic [3:0]  pc;
   logic [4:0]  prog_len;
   logic [1:0]  state;
   logic        overflow;

   int checks;
   int failures;

   riscv_mini_fetch #(.DEPTH(16), .NOP(16'h0003)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .clear       (clear),
      .start       (start),
      .halt        (halt),
      .taken       (taken),
      .target      (target),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .prog_len    (prog_len),
      .state       (state),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic load_instr(input logic [15:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_pc"}, 32'(pc), 32'd0);
      check({tag, "_prog_len"}, 32'(prog_len), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_instr"}, 32'(instr), 32'h0003);
      check({tag, "_valid"}, 32'(instr_valid), 32'd0);
   endtask

   int exp_pc [7];

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      byte_in    = 8'd0;
      byte_valid = 1'b0;
      clear      = 1'b0;
      start      = 1'b0;
      halt       = 1'b0;
      taken      = 1'b0;
      target     = 4'd0;
      exp_pc     = '{0, 1, 2, 0, 1, 2, 3};

      #3;
      check_reset_outputs("por");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Two-instruction program, straight-line run into DONE
      send_byte(8'h21);
      check("load_lo_state", 32'(state), 32'd1);
      send_byte(8'h04);
      check("load_hi_state", 32'(state), 32'd0);
      send_byte(8'h41);
      send_byte(8'h08);
      check("p2_prog_len", 32'(prog_len), 32'd2);
      pulse_start();
      check("p2_state_run", 32'(state), 32'd2);
      check("p2_pc0", 32'(pc), 32'd0);
      check("p2_instr0", 32'(instr), 32'h0421);
      check("p2_valid0", 32'(instr_valid), 32'd1);
      tick();
      check("p2_pc1", 32'(pc), 32'd1);
      check("p2_instr1", 32'(instr), 32'h0841);
      tick();
      check("p2_state_done", 32'(state), 32'd3);
      check("p2_done_instr", 32'(instr), 32'h0003);
      check("p2_done_valid", 32'(instr_valid), 32'd0);
      check("p2_done_pc", 32'(pc), 32'd1);

      // Halt beats taken, then a restart replays the same contents
      pulse_start();
      check("h_pc0", 32'(pc), 32'd0);
      tick();
      check("h_pc1", 32'(pc), 32'd1);
      halt   = 1'b1;
      taken  = 1'b1;
      target = 4'd0;
      tick();
      halt  = 1'b0;
      taken = 1'b0;
      check("h_state_idle", 32'(state), 32'd0);
      check("h_pc_zero", 32'(pc), 32'd0);
      check("h_valid", 32'(instr_valid), 32'd0);
      pulse_start();
      check("h_rerun_instr0", 32'(instr), 32'h0421);
      tick();
      check("h_rerun_instr1", 32'(instr), 32'h0841);
      tick();
      check("h_rerun_done", 32'(state), 32'd3);

      // Ignored starts: empty program, and mid-load
      pulse_clear();
      check("clr_done_state", 32'(state), 32'd0);
      check("clr_done_len", 32'(prog_len), 32'd0);
      pulse_start();
      check("start_empty_state", 32'(state), 32'd0);
      check("start_empty_valid", 32'(instr_valid), 32'd0);
      send_byte(8'h11);
      pulse_start();
      check("start_loadhi_state", 32'(state), 32'd1);
      send_byte(8'h22);
      check("p1_prog_len", 32'(prog_len), 32'd1);
      pulse_start();
      check("p1_instr", 32'(instr), 32'h2211);
      tick();
      check("p1_done", 32'(state), 32'd3);

      // Asynchronous reset while a high byte is pending
      pulse_clear();
      load_instr(16'hCAFE);
      send_byte(8'h55);
      byte_in    = 8'h66;
      byte_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_load");
      tick();
      byte_valid = 1'b0;
      rst_n      = 1'b1;
      check("rst_load_len_after", 32'(prog_len), 32'd0);
      check("rst_load_state_after", 32'(state), 32'd0);

      // Asynchronous reset while running
      load_instr(16'h1111);
      load_instr(16'h2222);
      pulse_start();
      tick();
      check("rst_run_instr1", 32'(instr), 32'h2222);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_run");
      tick();
      rst_n = 1'b1;

      // Backward branch: pc 0,1,2,0,1,2,3 then DONE
      for (int i = 0; i < 4; i++) load_instr(16'h1000 | 16'(i));
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         check($sformatf("br_pc%0d", i), 32'(pc), 32'(exp_pc[i]));
         check($sformatf("br_instr%0d", i), 32'(instr), 32'h1000 | 32'(exp_pc[i]));
         taken  = (i == 2);
         target = 4'd0;
         tick();
      end
      taken = 1'b0;
      check("br_done_state", 32'(state), 32'd3);
      check("br_done_pc", 32'(pc), 32'd3);

      // Full memory, overflow byte, jump to the last entry
      pulse_clear();
      for (int i = 0; i < 16; i++) load_instr(16'hA000 | 16'(i));
      check("full_len", 32'(prog_len), 32'd16);
      check("full_ovf_before", 32'(overflow), 32'd0);
      send_byte(8'hEE);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_len", 32'(prog_len), 32'd16);
      check("ovf_state", 32'(state), 32'd0);
      pulse_start();
      check("full_instr0", 32'(instr), 32'hA000);
      taken  = 1'b1;
      target = 4'd15;
      tick();
      taken = 1'b0;
      check("full_pc15", 32'(pc), 32'd15);
      check("full_instr15", 32'(instr), 32'hA00F);
      tick();
      check("full_done_state", 32'(state), 32'd3);
      check("full_done_pc", 32'(pc), 32'd15);
      check("ovf_sticky", 32'(overflow), 32'd1);
      pulse_clear();
      check("clr_full_len", 32'(prog_len), 32'd0);
      check("clr_full_ovf", 32'(overflow), 32'd0);

      // Clear drops a pending low byte; halt outside RUN is ignored
      send_byte(8'h77);
      pulse_clear();
      check("clr_loadhi_state", 32'(state), 32'd0);
      check("clr_loadhi_len", 32'(prog_len), 32'd0);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("halt_idle_state", 32'(state), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
